pong_game_controller: RTL
=========================

Name: pong_game_controller

Overview:
- Per-frame game sequencer for the two-player VGA pong display.
- Owns the ball position and velocity, runs the serve/play/score state machine, detects wall and paddle collisions and keeps both scores.
- Advances once per video frame, driven by the timing generator's screenEnd.
- Consumes paddle centre positions from the paddle movement logic and feeds ball_x/ball_y to the pixel renderer.

Parameters:
- VIDEO_WIDTH, 640, visible width in pixels
- VIDEO_HEIGHT, 480, visible height in pixels
- BALL_R, 8, ball half-size; the ball is a square of side 2*BALL_R
- PAD_HW, 25, paddle half-width
- PAD_HH, 33, paddle half-height
- SPEED, 2, pixels moved per axis per frame
- SERVE_FRAMES, 60, frames the ball is held centred before each serve
- WIN_SCORE, 5, score that ends the game

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- screen_end  in  1  level from the timing generator (clk25 domain), high between frames
- start  in  1  level request to begin a game
- p1_x  in  10  player 1 paddle centre x
- p1_y  in  9  player 1 paddle centre y
- p2_x  in  10  player 2 paddle centre x
- p2_y  in  9  player 2 paddle centre y
- ball_x  out  10  ball centre x
- ball_y  out  9  ball centre y
- score1  out  4  player 1 score
- score2  out  4  player 2 score
- goal  out  2  one-clk pulse on a goal: bit0 = p1 scored, bit1 = p2 scored
- game_over  out  1  high while in GAMEOVER
- state  out  3  current FSM state, for debug

Behaviour:
- Interfaces: one clock; reset is asynchronous and active-high; ports are named clk and reset.
- Tick generation: screen_end passes through a 2-FF synchroniser, then a rising-edge detect. The result is a one-clk pulse, tick.
  - All state updates happen only on a tick cycle.
  - Registered outputs change 3 clk edges after screen_end is first sampled high.
- Reset values:
  - ball = (VIDEO_WIDTH/2, VIDEO_HEIGHT/2) = (320, 240).
  - dx = right, dy = down.
  - Scores 0, goal 0, game_over 0.
  - state = IDLE, serve counter 0.
  - Synchroniser flops 0.
  - Reset asserted mid-game clears everything immediately.
- States: IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAMEOVER=4.
  - IDLE: ball centred. On a tick with start=1, go to SERVE with counter 0.
  - SERVE: ball centred. Each tick increments the counter. On the tick where the counter equals SERVE_FRAMES-1, go to PLAY (the first move happens on the next tick).
  - PLAY: on each tick apply the motion rules below.
  - SCORED: one tick long. Recentre the ball and toggle dy. Serve direction is toward the player who conceded. If either score equals WIN_SCORE, go to GAMEOVER; otherwise go to SERVE.
  - GAMEOVER: ball centred, scores held. On a tick with start=1, clear both scores and go to SERVE with dx = right.
- PLAY motion: compute in 11-bit signed arithmetic; never wrap.
  - Vertical: ny = y ± SPEED.
    - If ny <= BALL_R, then ny = BALL_R and dy becomes down.
    - If ny >= VIDEO_HEIGHT-1-BALL_R, then ny = VIDEO_HEIGHT-1-BALL_R and dy becomes up.
  - Paddle hit is evaluated on the pre-update position.
    - Moving left: hit if |x-p1_x| < PAD_HW+BALL_R and |y-p1_y| < PAD_HH+BALL_R. Set dx = right and nx = x+SPEED.
    - Moving right: same test against p2; set dx = left and nx = x-SPEED.
  - Goal, only if there was no paddle hit (a hit beats a goal in the same frame):
    - Left: moving left and nx <= BALL_R → score2++, goal[1] pulse, go to SCORED.
    - Right: moving right and nx >= VIDEO_WIDTH-1-BALL_R → score1++, goal[0] pulse, go to SCORED.
  - A wall bounce and a paddle hit in the same tick are both applied.
- Scores saturate at WIN_SCORE.
- start is ignored in SERVE, PLAY and SCORED.
- A tick is never lost. Consecutive ticks are at least 400k clk cycles apart, so each tick update is single-cycle.

Decomposition:
- Shared package pong_pkg:
  - VIDEO_WIDTH/VIDEO_HEIGHT constants.
  - State encoding constants.
  - Direction encoding (LEFT/RIGHT, UP/DOWN).
- Sub-module frame_tick_sync: 2-FF synchroniser plus rising-edge detect producing tick. It is reusable by the paddle movement logic.

Test Plan:
- Reset: pulse reset, then 10 ticks with start=0 → ball (320,240), scores 0/0, state 0, goal never pulses.
- Serve: start=1 on a tick, then 60 ticks → state 2; next tick → ball (322,242). Tick-to-output latency is 3 clk from screen_end rise.
- Top wall: PLAY with ball y=10 moving up, tick → y=8, dy down; next tick → y=10.
- Paddle: p1=(80,240), ball (112,250) moving left, tick → dx right, x=114, no goal. Repeat with ball (114,250): 34 ≥ 33, so no hit; x=112.
- Goal: p1_y=100, ball (10,240) moving left, tick → score2=1, goal=2'b10 for exactly 1 clk, state 3. Next tick → ball (320,240), state 1, subsequent serve moves left.
- Game over / reset: drive score1 to 5 → game_over=1, ball frozen. start → scores 0, SERVE. Assert reset mid-PLAY → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game logic.
//   - Screen geometry constants
//   - Game FSM state encoding
//   - Ball direction encodings
//   - absDiff helper for the 11-bit signed collision arithmetic
package pong_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    SCORED   = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } xDir_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } yDir_t;

  typedef logic signed [10:0] coord_t;

  // |a - b| without relying on a signed abs of a possibly wide subtraction.
  function automatic coord_t absDiff(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pong_game_controller_if.sv
// Signal bundle between the game controller and its neighbours.
//   screen_end      frame marker from the timing generator (other clock domain)
//   start           level request to begin a game
//   p1_x/p1_y       player 1 paddle centre
//   p2_x/p2_y       player 2 paddle centre
//   ball_x/ball_y   ball centre for the renderer
//   score1/score2   player scores
//   goal            one-clk goal pulse, bit0 = p1 scored, bit1 = p2 scored
//   game_over       high while the game is over
//   state           FSM state for debug
// master: the surrounding system (drives inputs, reads results)
// slave:  the game controller itself
interface pong_game_controller_if;
  logic       screen_end;
  logic       start;
  logic [9:0] p1_x;
  logic [8:0] p1_y;
  logic [9:0] p2_x;
  logic [8:0] p2_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] goal;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output screen_end, start, p1_x, p1_y, p2_x, p2_y,
    input  ball_x, ball_y, score1, score2, goal, game_over, state
  );

  modport slave (
    input  screen_end, start, p1_x, p1_y, p2_x, p2_y,
    output ball_x, ball_y, score1, score2, goal, game_over, state
  );
endinterface

// File: rtl/frame_tick_sync.sv
// Brings a frame-boundary level from another clock domain into clk and
// turns its rising edge into a single-cycle tick.
//   clk    system clock
//   reset  asynchronous active-high reset
//   level  asynchronous frame level (high between frames)
//   tick   one-clk pulse, high on the cycle after the level is seen twice
module frame_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  // [0],[1] form the synchroniser; [2] remembers the previous synced value.
  logic [2:0] syncReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncReg <= '0;
    end else begin
      syncReg <= {syncReg[1:0], level};
    end
  end

  assign tick = syncReg[1] & ~syncReg[2];

endmodule

// File: rtl/pong_game_controller.sv
// Per-frame pong sequencer: ball motion, wall/paddle collisions, scoring
// and the serve/play/score state machine. Everything advances on a tick
// derived from screen_end.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    pong_game_controller_if.slave (paddles/start in, ball/scores out)
module pong_game_controller
  import pong_pkg::*;
#(
  parameter int BALL_R       = 8,
  parameter int PAD_HW       = 25,
  parameter int PAD_HH       = 33,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input logic             clk,
  input logic             reset,
  pong_game_controller_if.slave bus
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] X_CENTRE = 10'(VIDEO_WIDTH / 2);
  localparam logic [8:0] Y_CENTRE = 9'(VIDEO_HEIGHT / 2);

  logic tick;

  state_t            stateReg, stateNext;
  logic [9:0]        ballXReg, ballXNext;
  logic [8:0]        ballYReg, ballYNext;
  xDir_t             dxReg, dxNext;
  yDir_t             dyReg, dyNext;
  logic [3:0]        score1Reg, score1Next;
  logic [3:0]        score2Reg, score2Next;
  logic [1:0]        goalReg, goalNext;
  logic [CNT_W-1:0]  cntReg, cntNext;

  coord_t curX, curY, nx, ny, padX, padY;
  logic   hit;

  frame_tick_sync tickSync (
    .clk   (clk),
    .reset (reset),
    .level (bus.screen_end),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      ballXReg  <= X_CENTRE;
      ballYReg  <= Y_CENTRE;
      dxReg     <= RIGHT;
      dyReg     <= DOWN;
      score1Reg <= '0;
      score2Reg <= '0;
      goalReg   <= '0;
      cntReg    <= '0;
    end else begin
      stateReg  <= stateNext;
      ballXReg  <= ballXNext;
      ballYReg  <= ballYNext;
      dxReg     <= dxNext;
      dyReg     <= dyNext;
      score1Reg <= score1Next;
      score2Reg <= score2Next;
      goalReg   <= goalNext;
      cntReg    <= cntNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    ballXNext  = ballXReg;
    ballYNext  = ballYReg;
    dxNext     = dxReg;
    dyNext     = dyReg;
    score1Next = score1Reg;
    score2Next = score2Reg;
    goalNext   = '0;          // goal is a pulse: cleared on every non-goal cycle
    cntNext    = cntReg;
    curX       = coord_t'({1'b0, ballXReg});
    curY       = coord_t'({2'b0, ballYReg});
    nx         = '0;
    ny         = '0;
    padX       = '0;
    padY       = '0;
    hit        = 1'b0;

    if (tick) begin
      case (stateReg)
        IDLE: begin
          ballXNext = X_CENTRE;
          ballYNext = Y_CENTRE;
          if (bus.start) begin
            stateNext = SERVE;
            cntNext   = '0;
          end
        end

        SERVE: begin
          ballXNext = X_CENTRE;
          ballYNext = Y_CENTRE;
          cntNext   = cntReg + CNT_W'(1);
          if (cntReg == CNT_W'(SERVE_FRAMES - 1)) begin
            stateNext = PLAY;
          end
        end

        PLAY: begin
          // Vertical move with clamping bounce off top/bottom walls.
          ny = (dyReg == UP) ? (curY - coord_t'(SPEED)) : (curY + coord_t'(SPEED));
          if (ny <= coord_t'(BALL_R)) begin
            ny     = coord_t'(BALL_R);
            dyNext = DOWN;
          end else if (ny >= coord_t'(VIDEO_HEIGHT - 1 - BALL_R)) begin
            ny     = coord_t'(VIDEO_HEIGHT - 1 - BALL_R);
            dyNext = UP;
          end

          // Only the paddle the ball is heading toward can be hit; the test
          // uses the position before this frame's move.
          padX = (dxReg == LEFT) ? coord_t'({1'b0, bus.p1_x}) : coord_t'({1'b0, bus.p2_x});
          padY = (dxReg == LEFT) ? coord_t'({2'b0, bus.p1_y}) : coord_t'({2'b0, bus.p2_y});
          hit  = (absDiff(curX, padX) < coord_t'(PAD_HW + BALL_R)) &&
                 (absDiff(curY, padY) < coord_t'(PAD_HH + BALL_R));
          if (hit) begin
            dxNext = (dxReg == LEFT) ? RIGHT : LEFT;
          end
          nx = (dxNext == LEFT) ? (curX - coord_t'(SPEED)) : (curX + coord_t'(SPEED));

          // A paddle hit in the same frame always wins over a goal.
          if (!hit && dxReg == LEFT && nx <= coord_t'(BALL_R)) begin
            if (score2Reg < 4'(WIN_SCORE)) score2Next = score2Reg + 4'd1;
            goalNext  = 2'b10;
            stateNext = SCORED;
          end else if (!hit && dxReg == RIGHT && nx >= coord_t'(VIDEO_WIDTH - 1 - BALL_R)) begin
            if (score1Reg < 4'(WIN_SCORE)) score1Next = score1Reg + 4'd1;
            goalNext  = 2'b01;
            stateNext = SCORED;
          end

          ballXNext = nx[9:0];
          ballYNext = ny[8:0];
        end

        SCORED: begin
          // dx is left untouched: the ball was travelling toward the player
          // who conceded, which is the serve direction.
          ballXNext = X_CENTRE;
          ballYNext = Y_CENTRE;
          dyNext    = (dyReg == UP) ? DOWN : UP;
          cntNext   = '0;
          if (score1Reg == 4'(WIN_SCORE) || score2Reg == 4'(WIN_SCORE)) begin
            stateNext = GAMEOVER;
          end else begin
            stateNext = SERVE;
          end
        end

        GAMEOVER: begin
          ballXNext = X_CENTRE;
          ballYNext = Y_CENTRE;
          if (bus.start) begin
            score1Next = '0;
            score2Next = '0;
            dxNext     = RIGHT;
            cntNext    = '0;
            stateNext  = SERVE;
          end
        end

        default: stateNext = IDLE;
      endcase
    end
  end

  assign bus.ball_x    = ballXReg;
  assign bus.ball_y    = ballYReg;
  assign bus.score1    = score1Reg;
  assign bus.score2    = score2Reg;
  assign bus.goal      = goalReg;
  assign bus.game_over = (stateReg == GAMEOVER);
  assign bus.state     = stateReg;

endmodule
